fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register sitting directly upstream of the control decoder. Holds the PC and issues one-outstanding-request fetches to instruction memory over a req/ack handshake with variable latency. Absorbs hazard stalls with a one-entry skid buffer and squashes wrong-path fetches on branch/jump redirects. Presents the decoded fields `OpCode`/`funct` plus PC values to the decode stage.

---
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, one-outstanding imem req/ack and IF/ID pipeline register.
// Latency: IF/ID valid one cycle after the imem ack (zero-wait memory gives throughput 1).
// Backpressure: stall holds IF/ID; a fetch completing under stall parks in a one-entry skid.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct
);

  // FETCH: request in flight or being issued; DROP: in-flight request is wrong-path;
  // HOLD: fetched word parked in skid, no request while decode is stalled.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        req_en_q;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        ack_v;
  logic [31:0] rpc;
  logic        load;
  logic [31:0] ld_pc;
  logic [31:0] ld_instr;

  // Redirect targets are always word aligned.
  assign rpc       = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req  = req_en_q & ((state_q == S_FETCH) || (state_q == S_DROP));
  assign imem_addr = pc_q;
  // An ack only counts against a request we are actually presenting.
  assign ack_v     = imem_ack & imem_req;

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;
  assign OpCode     = ifid_instr_q[31:26];
  assign funct      = ifid_instr_q[5:0];

  // Next-state for fetch control, PC, skid, and the IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load         = 1'b0;
    ld_pc        = 32'h0;
    ld_instr     = 32'h0;

    case (state_q)
      S_FETCH: begin
        if (ack_v) begin
          if (redirect) begin
            pc_d = rpc;
          end else if (!stall) begin
            load     = 1'b1;
            ld_pc    = pc_q;
            ld_instr = imem_rdata;
            pc_d     = pc_q + 32'd4;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            pc_d         = pc_q + 32'd4;
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          // Address must stay put while a request is pending; remember the target.
          if (imem_req) begin
            tgt_d   = rpc;
            state_d = S_DROP;
          end else begin
            pc_d = rpc;
          end
        end
      end
      S_DROP: begin
        if (redirect) tgt_d = rpc;
        if (ack_v) begin
          pc_d    = redirect ? rpc : tgt_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = rpc;
          state_d = S_FETCH;
        end else if (!stall) begin
          load     = 1'b1;
          ld_pc    = skid_pc_q;
          ld_instr = skid_instr_q;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    if (redirect) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'h0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
    end else if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = ld_pc;
      ifid_pc4_d   = ld_pc + 32'd4;
      ifid_instr_d = ld_instr;
    end else begin
      // Bubble: decodes as NOP, PC fields keep their last value.
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'h0;
    end
  end

  // State registers; req_en comes up one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      req_en_q     <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      req_en_q     <= 1'b1;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [5:0]  OpCode;
  logic [5:0]  funct;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .OpCode(OpCode), .funct(funct)
  );

  int total = 0;
  int bad = 0;
  int consumed = 0;
  // Program-order stream of PCs decode must see next; reset/redirect restart it.
  logic [31:0] exp_q[$];
  int lat_min = 0;
  int lat_max = 0;
  int lat = 0;
  int wcnt = 0;
  logic        prev_pend;
  logic [31:0] prev_addr;
  logic [31:0] e_instr;
  logic [31:0] got_pc;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    wcnt = 0;
    lat  = int'($urandom_range(lat_max, lat_min));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_req"}, imem_req, 1'b0);
    chk({tag, "_addr"}, imem_addr, RST_PC);
    chk1({tag, "_vld"}, ifid_valid, 1'b0);
    chk({tag, "_pc"}, ifid_pc, 32'h0);
    chk({tag, "_pc4"}, ifid_pc4, 32'h0);
    chk({tag, "_instr"}, ifid_instr, 32'h0);
    chk({tag, "_dec"}, {20'h0, OpCode, funct}, 32'h0);
  endtask

  // Advance one cycle: drive hazard inputs and the variable-latency memory.
  task automatic cycle(input logic s, input logic r, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (r) begin
      exp_q.delete();
      exp_q.push_back(rpc & 32'hFFFF_FFFC);
    end
    while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        wcnt       = 0;
        lat        = int'($urandom_range(lat_max, lat_min));
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Monitor: checks every cycle's IF/ID contents and pops the scoreboard when decode consumes.
  initial begin
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          chk1("req_held", imem_req, 1'b1);
          chk("addr_held", imem_addr, prev_addr);
        end
        if (!ifid_valid) begin
          chk("bubble_instr", ifid_instr, 32'h0);
          chk("bubble_dec", {20'h0, OpCode, funct}, 32'h0);
        end else begin
          e_instr = memf(ifid_pc);
          chk("pc4", ifid_pc4, ifid_pc + 32'd4);
          chk("instr", ifid_instr, e_instr);
          chk("decode", {20'h0, OpCode, funct}, {20'h0, e_instr[31:26], e_instr[5:0]});
          if (!stall && !redirect) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL order: got pc %h expected no instruction", ifid_pc);
            end else begin
              got_pc = exp_q.pop_front();
              chk("order", ifid_pc, got_pc);
              consumed++;
            end
          end
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  int c_start;
  logic s_r, r_r;
  logic [31:0] rpc_r;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;                             // cycle 0
    chk1("c0_req", imem_req, 1'b0);
    cycle(0, 0, 0);                           // cycle 1
    chk1("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, 32'h3000);
    chk1("c1_vld", ifid_valid, 1'b0);
    cycle(0, 0, 0);                           // cycle 2
    chk1("c2_vld", ifid_valid, 1'b1);
    chk("c2_pc", ifid_pc, 32'h3000);
    chk("c2_pc4", ifid_pc4, 32'h3004);
    cycle(1, 0, 0);                           // cycle 3: 0x3008 arrives under stall
    chk("c3_pc", ifid_pc, 32'h3004);
    cycle(1, 0, 0);
    chk("c4_pc", ifid_pc, 32'h3004);
    chk1("c4_noreq", imem_req, 1'b0);
    cycle(1, 0, 0);
    chk("c5_pc", ifid_pc, 32'h3004);
    chk1("c5_noreq", imem_req, 1'b0);
    cycle(0, 0, 0);
    chk("c6_pc", ifid_pc, 32'h3004);
    chk1("c6_noreq", imem_req, 1'b0);
    cycle(0, 0, 0);
    chk("c7_pc", ifid_pc, 32'h3008);
    lat_min = 3; lat_max = 3;
    cycle(0, 0, 0);
    chk("c8_pc", ifid_pc, 32'h300C);
    cycle(0, 0, 0);                           // first wait cycle of 0x3014
    chk("c9_addr", imem_addr, 32'h3014);
    cycle(0, 1, 32'h3100);                    // redirect in second wait cycle
    chk("c10_addr", imem_addr, 32'h3014);
    cycle(0, 0, 0);
    chk("c11_addr", imem_addr, 32'h3014);
    chk1("c11_vld", ifid_valid, 1'b0);
    lat_min = 0; lat_max = 0;
    cycle(0, 0, 0);                           // late ack of squashed fetch
    chk("c12_addr", imem_addr, 32'h3014);
    chk1("c12_vld", ifid_valid, 1'b0);
    cycle(0, 0, 0);
    chk1("c13_req", imem_req, 1'b1);
    chk("c13_addr", imem_addr, 32'h3100);
    chk1("c13_vld", ifid_valid, 1'b0);
    cycle(0, 0, 0);
    chk("c14_pc", ifid_pc, 32'h3100);
    cycle(0, 0, 0);
    chk("c15_pc", ifid_pc, 32'h3104);
    cycle(1, 1, 32'h3200);                    // redirect + stall with valid IF/ID
    chk1("c16_vld", ifid_valid, 1'b1);
    chk("c16_pc", ifid_pc, 32'h3108);
    cycle(0, 0, 0);
    chk1("c17_vld", ifid_valid, 1'b0);
    chk("c17_instr", ifid_instr, 32'h0);
    chk("c17_dec", {20'h0, OpCode, funct}, 32'h0);
    chk("c17_addr", imem_addr, 32'h3200);
    cycle(0, 0, 0);
    chk("c18_pc", ifid_pc, 32'h3200);
    cycle(0, 1, 32'hFFFF_FFFF);
    cycle(0, 0, 0);
    chk("c20_addr", imem_addr, 32'hFFFF_FFFC);
    lat_min = 5; lat_max = 5;
    cycle(0, 0, 0);
    chk("c21_addr", imem_addr, 32'h0);
    chk("c21_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("c21_pc4", ifid_pc4, 32'h0);
    cycle(0, 0, 0);
    chk1("c22_req", imem_req, 1'b1);
    chk("c22_addr", imem_addr, 32'h4);
    cycle(0, 0, 0);
    #2;
    rst_n = 1'b0;                             // reset mid-request
    lat_min = 0; lat_max = 0;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;                             // cycle 0 with the stale ack
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk1("r0_req", imem_req, 1'b0);
    cycle(0, 0, 0);
    chk1("r1_vld", ifid_valid, 1'b0);
    chk("r1_addr", imem_addr, RST_PC);
    cycle(0, 0, 0);
    chk("r2_pc", ifid_pc, RST_PC);

    c_start = consumed;
    for (int blk = 0; blk < 6; blk++) begin
      lat_min = int'($urandom_range(1, 0));
      lat_max = lat_min + int'($urandom_range(3, 0));
      for (int i = 0; i < 500; i++) begin
        s_r = ($urandom_range(99, 0) < 25);
        r_r = ($urandom_range(99, 0) < 8);
        case ($urandom_range(3, 0))
          0:       rpc_r = $urandom;
          1:       rpc_r = 32'hFFFF_FFF0 + $urandom_range(15, 0);
          default: rpc_r = 32'h3000 + ($urandom_range(255, 0) << 2);
        endcase
        cycle(s_r, r_r, rpc_r);
      end
    end
    repeat (8) cycle(0, 0, 0);
    chk1("progress", (consumed - c_start) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
